// File: rtl/console_pkg.sv
// Shared types and bit positions for the switch-bus console driver.
// Imported by the FIFO and the driver top level.
package console_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        ERROR
    } state_t;

    localparam int SW_DATA_LSB  = 0;
    localparam int SW_REQ_BIT   = 8;
    localparam int LEDG_ACK_BIT = 0;

endpackage

// File: rtl/console_fifo.sv
// Synchronous DEPTH x 8 byte FIFO with wrapping pointers.
// A push is taken only when not full at the start of the cycle.
module console_fifo
    import console_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;
    logic          w_acc_push;
    logic          w_acc_pop;

    assign o_full     = (r_level == LW'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd];
    assign w_acc_push = i_push & ~o_full;
    assign w_acc_pop  = i_pop & ~o_empty;

    // Storage array; contents need no reset since level gates reads.
    always_ff @(posedge i_clk) begin
        if (w_acc_push) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_acc_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_acc_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_level <= r_level + LW'(w_acc_push) - LW'(w_acc_pop);
        end
    end

endmodule

// File: rtl/console_sw_driver.sv
// Streams queued bytes onto the core's switch bus with a toggle
// request / toggle acknowledge handshake, plus counters and error flags.
module console_sw_driver
    import console_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [7:0]             i_push_data,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [31:0]            o_io_sw,
    input  logic [31:0]            i_io_ledg,
    output logic [31:0]            o_sent_cnt,
    output logic                   o_overflow,
    output logic                   o_timeout,
    output logic                   o_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_sw_data;
    logic          r_req;
    logic          r_ack_q;
    logic [TW-1:0] r_timer;
    logic [31:0]   r_sent_cnt;
    logic          r_overflow;
    logic          r_timeout;
    logic          w_pop;
    logic          w_done;
    logic          w_expire;
    logic          w_empty;
    logic [7:0]    w_pop_data;
    logic          w_unused;

    assign w_unused = ^i_io_ledg[31:1];

    console_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (i_push),
        .i_push_data (i_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (o_full),
        .o_empty     (w_empty),
        .o_level     (o_level)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and the single-cycle control strobes.
    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_done   = 1'b0;
        w_expire = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (r_ack_q == r_req) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_expire = 1'b1;
                    w_next   = ERROR;
                end
            end
            ERROR: begin
                w_next = ERROR;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Switch bus, ack sampling, timer, counter and sticky flags.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_sw_data  <= '0;
            r_req      <= 1'b0;
            r_ack_q    <= 1'b0;
            r_timer    <= '0;
            r_sent_cnt <= '0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_ack_q <= i_io_ledg[LEDG_ACK_BIT];
            if (w_pop) begin
                r_sw_data <= w_pop_data;
                r_req     <= ~r_req;
                r_timer   <= '0;
            end else if (r_state == WAIT_ACK && !w_done && !w_expire) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_done) begin
                r_sent_cnt <= r_sent_cnt + 32'd1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
            if (i_push && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Drive the switch word: data byte, request toggle, zeros above.
    always_comb begin
        o_io_sw                       = '0;
        o_io_sw[SW_DATA_LSB +: 8]     = r_sw_data;
        o_io_sw[SW_REQ_BIT]           = r_req;
    end

    assign o_sent_cnt = r_sent_cnt;
    assign o_overflow = r_overflow;
    assign o_timeout  = r_timeout;
    assign o_busy     = (r_state == WAIT_ACK);

endmodule

// File: tb/tb_console_sw_driver.sv
// Self-checking bench for console_sw_driver with a program-side
// responder model and an expected/received byte scoreboard.
module tb_console_sw_driver;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic [7:0]  push_data = 8'h00;
    logic        full;
    logic [4:0]  level;
    logic [31:0] sw;
    logic [31:0] ledg = 32'h0;
    logic [31:0] sent;
    logic        ovf;
    logic        tmo;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    logic       m_req = 1'b0;

    bit resp_en  = 1'b0;
    int resp_dly = 0;
    bit last_seen = 1'b0;
    bit pend = 1'b0;
    int pcnt = 0;

    console_sw_driver #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_push     (push),
        .i_push_data(push_data),
        .o_full     (full),
        .o_level    (level),
        .o_io_sw    (sw),
        .i_io_ledg  (ledg),
        .o_sent_cnt (sent),
        .o_overflow (ovf),
        .o_timeout  (tmo),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Program-side model: polls sw[8], records bytes, echoes the toggle.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_seen = 1'b0;
            pend      = 1'b0;
            ledg      = 32'h0;
        end else begin
            if (pend) begin
                if (pcnt <= 0) begin
                    ledg[0] = last_seen;
                    pend    = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            if (sw[8] !== last_seen) begin
                last_seen = sw[8];
                rx_q.push_back(sw[8:0]);
                if (resp_en) begin
                    if (resp_dly == 0) begin
                        ledg[0] = sw[8];
                    end else begin
                        pend = 1'b1;
                        pcnt = resp_dly - 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        m_req = ~m_req;
        exp_q.push_back({m_req, b});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        push  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
        m_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) step();
        n_vec++;
        if (sw !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_sw got %h want 0", sw);
        end
        n_vec++;
        if (level !== 5'd0 || full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_level got %0d/%b want 0/0", level, full);
        end
        n_vec++;
        if (sent !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_sent got %0d want 0", sent);
        end
        n_vec++;
        if ({ovf, tmo, busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 000", {ovf, tmo, busy});
        end
    endtask

    task automatic test_single();
        logic [8:0] e;
        logic [8:0] r;
        int k;
        do_reset();
        resp_en  = 1'b1;
        resp_dly = 2;
        push      = 1'b1;
        push_data = 8'h41;
        expect_byte(8'h41);
        step();
        push = 1'b0;
        n_vec++;
        if (level !== 5'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_edgeN level/busy got %0d/%b want 1/0",
                     level, busy);
        end
        step();
        n_vec++;
        if (sw !== 32'h0000_0141 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_present sw/busy got %h/%b want 00000141/1",
                     sw, busy);
        end
        k = 0;
        while (k < 30 && !(sent == 32'd1 && !busy)) begin
            step();
            k++;
        end
        n_vec++;
        if (sent !== 32'd1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done sent/busy got %0d/%b want 1/0",
                     sent, busy);
        end
        e = exp_q.pop_front();
        r = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
        n_vec++;
        if (r !== e) begin
            n_bad++;
            $display("FAIL single_rx got %h want %h", r, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [8:0] e;
        logic [8:0] r;
        int k;
        bytes[0] = 8'h48;
        bytes[1] = 8'h69;
        bytes[2] = 8'h0A;
        do_reset();
        resp_en  = 1'b1;
        resp_dly = 0;
        for (int i = 0; i < 3; i++) begin
            push      = 1'b1;
            push_data = bytes[i];
            expect_byte(bytes[i]);
            step();
        end
        push = 1'b0;
        k = 0;
        while (k < 100 && !(sent == 32'd3 && level == 5'd0 && !busy)) begin
            step();
            k++;
        end
        n_vec++;
        if (sent !== 32'd3 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL b2b_done sent/level got %0d/%0d want 3/0",
                     sent, level);
        end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
            n_vec++;
            if (r !== e) begin
                n_bad++;
                $display("FAIL b2b_rx%0d got %h want %h", i, r, e);
            end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] e;
        logic [8:0] r;
        int k;
        do_reset();
        resp_en  = 1'b1;
        resp_dly = 0;
        for (int i = 0; i < 40; i++) begin
            push      = 1'b1;
            push_data = 8'(i);
            expect_byte(8'(i));
            step();
            push = 1'b0;
            if (i % 4 != 3) begin
                step();
                step();
            end
        end
        k = 0;
        while (k < 500 && !(sent == 32'd40 && level == 5'd0 && !busy)) begin
            step();
            k++;
        end
        n_vec++;
        if (sent !== 32'd40 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL wrap_done sent/level got %0d/%0d want 40/0",
                     sent, level);
        end
        n_vec++;
        if (ovf !== 1'b0 || tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_flags ovf/tmo got %b/%b want 0/0", ovf, tmo);
        end
        for (int i = 0; i < 40; i++) begin
            e = exp_q.pop_front();
            r = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
            n_vec++;
            if (r !== e) begin
                n_bad++;
                $display("FAIL wrap_rx%0d got %h want %h", i, r, e);
            end
        end
    endtask

    task automatic test_overflow_timeout();
        int t_entry;
        int t_to;
        int k;
        logic [8:0] e;
        logic [8:0] r;
        do_reset();
        resp_en = 1'b0;
        t_entry = 0;
        for (int i = 0; i < 17; i++) begin
            push      = 1'b1;
            push_data = 8'(8'h80 + i);
            expect_byte(8'(8'h80 + i));
            step();
            if (i == 1) t_entry = cyc;
        end
        push = 1'b0;
        n_vec++;
        if (level !== 5'd16 || full !== 1'b1 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_fill level/full/ovf got %0d/%b/%b want 16/1/0",
                     level, full, ovf);
        end
        push      = 1'b1;
        push_data = 8'hEE;
        step();
        push = 1'b0;
        n_vec++;
        if (ovf !== 1'b1 || level !== 5'd16) begin
            n_bad++;
            $display("FAIL ovf_drop ovf/level got %b/%0d want 1/16",
                     ovf, level);
        end
        k = 0;
        while (k < 1200 && !tmo) begin
            step();
            k++;
        end
        t_to = cyc;
        n_vec++;
        if (tmo !== 1'b1 || (t_to - t_entry) != TIMEOUT) begin
            n_bad++;
            $display("FAIL timeout_at tmo/cycles got %b/%0d want 1/%0d",
                     tmo, t_to - t_entry, TIMEOUT);
        end
        step();
        n_vec++;
        if (busy !== 1'b0 || level !== 5'd16 || sw !== 32'h0000_0180) begin
            n_bad++;
            $display("FAIL error_hold busy/level/sw got %b/%0d/%h want 0/16/00000180",
                     busy, level, sw);
        end
        e = exp_q.pop_front();
        r = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
        n_vec++;
        if (r !== e || rx_q.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_rx got %h (+%0d) want %h (+0)",
                     r, rx_q.size(), e);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        resp_en  = 1'b1;
        resp_dly = 0;
        push      = 1'b1;
        push_data = 8'h55;
        step();
        push = 1'b0;
        k = 0;
        while (k < 30 && !(sent == 32'd1 && !busy)) begin
            step();
            k++;
        end
        resp_en   = 1'b0;
        push      = 1'b1;
        push_data = 8'h66;
        step();
        push_data = 8'h77;
        step();
        push = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || sent !== 32'd1 || level !== 5'd1) begin
            n_bad++;
            $display("FAIL mid_pre busy/sent/level got %b/%0d/%0d want 1/1/1",
                     busy, sent, level);
        end
        rst_n = 1'b0;
        step();
        n_vec++;
        if (sw !== 32'h0 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL mid_reset sw/level got %h/%0d want 0/0", sw, level);
        end
        n_vec++;
        if (busy !== 1'b0 || sent !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_state busy/sent got %b/%0d want 0/0", busy, sent);
        end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_overflow_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
